// File: rtl/mux_1_4_en_s4.sv
// Four-to-one single-bit mux with active-high enable and a one-hot select view,
// plus a registered copy of both for downstream synchronous logic.
module mux_1_4_en_s4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] sel,
    input  logic [3:0] in,
    output logic       out,
    output logic [3:0] sel_oh,
    output logic       out_q,
    output logic [3:0] sel_oh_q
);

    // Stage 0: combinational select; the ternary lets an unknown en propagate as X
    always_comb begin
        sel_oh = en ? (4'b0001 << sel) : 4'b0000;
        out    = en ? in[sel] : 1'b0;
    end

    // Stage 1: registered copy, cleared asynchronously and reloaded every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= 1'b0;
            sel_oh_q <= 4'b0000;
        end else begin
            out_q    <= out;
            sel_oh_q <= sel_oh;
        end
    end

endmodule

// File: tb/tb_mux_1_4_en_s4.sv
// Directed bench for mux_1_4_en_s4: combinational select, one-hot decode,
// one-cycle registered lag and asynchronous reset behaviour.
module tb_mux_1_4_en_s4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic [3:0] in;
    logic       out;
    logic [3:0] sel_oh;
    logic       out_q;
    logic [3:0] sel_oh_q;

    int vectors;
    int miscompares;

    mux_1_4_en_s4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sel      (sel),
        .in       (in),
        .out      (out),
        .sel_oh   (sel_oh),
        .out_q    (out_q),
        .sel_oh_q (sel_oh_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        sel   = 2'b11;
        in    = 4'b1000;
        #1;
        vectors++;
        if (out_q !== 1'b0) begin
            $display("FAIL reset_out_q: got %b want 0", out_q);
            miscompares++;
        end
        vectors++;
        if (sel_oh_q !== 4'b0000) begin
            $display("FAIL reset_sel_oh_q: got %b want 0000", sel_oh_q);
            miscompares++;
        end
        vectors++;
        if (out !== 1'b1 || sel_oh !== 4'b1000) begin
            $display("FAIL reset_comb: got out=%b sel_oh=%b want 1 1000", out, sel_oh);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_q !== 1'b0 || sel_oh_q !== 4'b0000) begin
            $display("FAIL reset_hold: got out_q=%b sel_oh_q=%b want 0 0000", out_q, sel_oh_q);
            miscompares++;
        end
    endtask

    task automatic test_registered_latency;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        sel   = 2'b11;
        in    = 4'b1000;
        #1;
        vectors++;
        if (out_q !== 1'b0 || sel_oh_q !== 4'b0000) begin
            $display("FAIL latency_before_edge: got out_q=%b sel_oh_q=%b want 0 0000", out_q, sel_oh_q);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_q !== 1'b1 || sel_oh_q !== 4'b1000) begin
            $display("FAIL latency_after_edge: got out_q=%b sel_oh_q=%b want 1 1000", out_q, sel_oh_q);
            miscompares++;
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_q !== 1'b0 || sel_oh_q !== 4'b0000) begin
            $display("FAIL async_clear: got out_q=%b sel_oh_q=%b want 0 0000", out_q, sel_oh_q);
            miscompares++;
        end
        vectors++;
        if (out !== 1'b1 || sel_oh !== 4'b1000) begin
            $display("FAIL async_comb: got out=%b sel_oh=%b want 1 1000", out, sel_oh);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_q !== 1'b0) begin
            $display("FAIL async_release_early: got out_q=%b want 0", out_q);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_q !== 1'b1 || sel_oh_q !== 4'b1000) begin
            $display("FAIL async_reload: got out_q=%b sel_oh_q=%b want 1 1000", out_q, sel_oh_q);
            miscompares++;
        end
    endtask

    task automatic test_disabled_sweep;
        logic [1:0] s;
        en = 1'b0;
        in = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            s   = i[1:0];
            sel = s;
            #10;
            vectors++;
            if (out !== 1'b0 || sel_oh !== 4'b0000) begin
                $display("FAIL disabled_sel%0d: got out=%b sel_oh=%b want 0 0000", i, out, sel_oh);
                miscompares++;
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (out_q !== 1'b0 || sel_oh_q !== 4'b0000) begin
            $display("FAIL disabled_reg: got out_q=%b sel_oh_q=%b want 0 0000", out_q, sel_oh_q);
            miscompares++;
        end
    endtask

    task automatic test_enabled_sweep;
        logic       exp_out [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_oh  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [1:0] s;
        en = 1'b1;
        in = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            s   = i[1:0];
            sel = s;
            #10;
            vectors++;
            if (out !== exp_out[i] || sel_oh !== exp_oh[i]) begin
                $display("FAIL enabled_sel%0d: got out=%b sel_oh=%b want %b %b",
                         i, out, sel_oh, exp_out[i], exp_oh[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_input_toggle;
        logic [3:0] vec     [3] = '{4'b0000, 4'b0100, 4'b1011};
        logic       exp_out [3] = '{1'b0, 1'b1, 1'b0};
        logic       prev_q;
        @(negedge clk);
        en  = 1'b1;
        sel = 2'b10;
        in  = vec[0];
        @(posedge clk); #1;
        prev_q = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in = vec[i];
            #1;
            vectors++;
            if (out !== exp_out[i] || out_q !== prev_q) begin
                $display("FAIL toggle_immediate%0d: got out=%b out_q=%b want %b %b",
                         i, out, out_q, exp_out[i], prev_q);
                miscompares++;
            end
            @(posedge clk); #1;
            vectors++;
            if (out_q !== exp_out[i]) begin
                $display("FAIL toggle_registered%0d: got out_q=%b want %b", i, out_q, exp_out[i]);
                miscompares++;
            end
            prev_q = exp_out[i];
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] sels   [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        logic       exp_q  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_oh [4] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
        @(negedge clk);
        en = 1'b1;
        in = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            sel = sels[i];
            @(posedge clk); #1;
            vectors++;
            if (out_q !== exp_q[i] || sel_oh_q !== exp_oh[i]) begin
                $display("FAIL b2b_%0d: got out_q=%b sel_oh_q=%b want %b %b",
                         i, out_q, sel_oh_q, exp_q[i], exp_oh[i]);
                miscompares++;
            end
            vectors++;
            if (out !== |(sel_oh & in)) begin
                $display("FAIL b2b_or_reduce%0d: got out=%b want %b", i, out, |(sel_oh & in));
                miscompares++;
            end
        end
    endtask

    task automatic test_enable_drop;
        @(negedge clk);
        en  = 1'b1;
        sel = 2'b01;
        in  = 4'b0010;
        @(posedge clk); #1;
        vectors++;
        if (out_q !== 1'b1 || sel_oh_q !== 4'b0010) begin
            $display("FAIL drop_enabled_reg: got out_q=%b sel_oh_q=%b want 1 0010", out_q, sel_oh_q);
            miscompares++;
        end
        @(negedge clk);
        en = 1'b0;
        #1;
        vectors++;
        if (out !== 1'b0 || sel_oh !== 4'b0000) begin
            $display("FAIL drop_comb: got out=%b sel_oh=%b want 0 0000", out, sel_oh);
            miscompares++;
        end
        vectors++;
        if (out_q !== 1'b1) begin
            $display("FAIL drop_reg_early: got out_q=%b want 1", out_q);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (out_q !== 1'b0 || sel_oh_q !== 4'b0000) begin
            $display("FAIL drop_reg: got out_q=%b sel_oh_q=%b want 0 0000", out_q, sel_oh_q);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_registered_latency();
        test_async_reset();
        test_disabled_sweep();
        test_enabled_sweep();
        test_input_toggle();
        test_back_to_back();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
